// File: rtl/cyc_24_pucch1_sched.sv
// -----------------------------------------------------------------------------
// cyc_24_pucch1_sched
//
// PUCCH format 1 spreading scheduler.
//
// This block accepts one PUCCH-1 allocation and checks it. If the allocation is
// accepted, it runs the external block-wise spreading-sequence generator one
// hop at a time. For every data symbol it emits one phase word phi(m) on a
// ready/valid stream. All error reporting is done here, so the spreader is only
// started with an nSF value that it supports.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_start           one-cycle request (ignored unless idle)
//   i_nsym            PUCCH symbol count N (4..14 valid)
//   i_start_sym       first PUCCH symbol in slot
//   i_hop             intra-slot hopping enable
//   i_occi            time-domain OCC index
//   o_sp_start        spreader start strobe
//   o_sp_next         spreader advance strobe
//   o_sp_nsf          nSF of the current hop
//   o_sp_occi         latched OCC index
//   i_sp_phi          spreader phi(m), units of 2*pi/24
//   i_sp_valid        spreader output valid
//   i_sp_done         spreader is at the last m of the hop
//   o_valid, i_ready  output beat handshake
//   o_phi, o_sym      phase word and absolute slot symbol of the beat
//   o_hop, o_m        hop index and index m within the hop
//   o_busy            high in every state except IDLE
//   o_done            one-cycle pulse when the allocation is complete
//   o_err             one-cycle pulse when the allocation is rejected
//   o_err_code        1=range, 2=unsupported nSF, 3=occi >= nSF (held)
// -----------------------------------------------------------------------------
module cyc_24_pucch1_sched (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [3:0] i_nsym,
    input  logic [3:0] i_start_sym,
    input  logic       i_hop,
    input  logic [2:0] i_occi,
    output logic       o_sp_start,
    output logic       o_sp_next,
    output logic [2:0] o_sp_nsf,
    output logic [2:0] o_sp_occi,
    input  logic [4:0] i_sp_phi,
    input  logic       i_sp_valid,
    input  logic       i_sp_done,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [4:0] o_phi,
    output logic [3:0] o_sym,
    output logic       o_hop,
    output logic [2:0] o_m,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [1:0] o_err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_SP_START,
        S_SP_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t     state_q, state_d;

    // Latched allocation
    logic [3:0] nsym_q, nsym_d;
    logic [3:0] ssym_q, ssym_d;
    logic       hop_en_q, hop_en_d;
    logic [2:0] occi_q, occi_d;

    // Run-time state
    logic [2:0] nsf_q, nsf_d;
    logic       hop_q, hop_d;
    logic [2:0] k_q, k_d;        // data-symbol counter across both hops
    logic [2:0] m_q, m_d;        // index within current hop
    logic       last_q, last_d;  // captured i_sp_done of the held beat

    // Output beat registers
    logic [4:0] phi_q, phi_d;
    logic [3:0] sym_q, sym_d;
    logic       ohop_q, ohop_d;
    logic [2:0] om_q, om_d;

    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;

    // Hop geometry from the latched allocation
    logic [2:0] half_c;
    logic [2:0] quarter_c;
    logic [2:0] nsf0_c;
    logic [2:0] nsf1_c;
    logic [2:0] min_nsf_c;
    logic [4:0] end_sym_c;
    logic       range_bad_c;
    logic       nsf_bad_c;
    logic       occi_bad_c;

    function automatic logic nsf_supported(input logic [2:0] n);
        return (n == 3'd1) || (n == 3'd2) || (n == 3'd3) || (n == 3'd4) || (n == 3'd6);
    endfunction

    always_comb begin
        half_c      = nsym_q[3:1];
        quarter_c   = {1'b0, nsym_q[3:2]};
        nsf0_c      = hop_en_q ? quarter_c : half_c;
        nsf1_c      = half_c - quarter_c;
        min_nsf_c   = (hop_en_q && (nsf1_c < nsf0_c)) ? nsf1_c : nsf0_c;
        end_sym_c   = {1'b0, ssym_q} + {1'b0, nsym_q};
        range_bad_c = (nsym_q < 4'd4) || (nsym_q > 4'd14) || (end_sym_c > 5'd14);
        nsf_bad_c   = !nsf_supported(nsf0_c) || (hop_en_q && !nsf_supported(nsf1_c));
        occi_bad_c  = (occi_q >= min_nsf_c);
    end

    always_comb begin
        state_d    = state_q;
        nsym_d     = nsym_q;
        ssym_d     = ssym_q;
        hop_en_d   = hop_en_q;
        occi_d     = occi_q;
        nsf_d      = nsf_q;
        hop_d      = hop_q;
        k_d        = k_q;
        m_d        = m_q;
        last_d     = last_q;
        phi_d      = phi_q;
        sym_d      = sym_q;
        ohop_d     = ohop_q;
        om_d       = om_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        o_sp_start = 1'b0;
        o_sp_next  = 1'b0;
        o_valid    = 1'b0;
        o_done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    nsym_d     = i_nsym;
                    ssym_d     = i_start_sym;
                    hop_en_d   = i_hop;
                    occi_d     = i_occi;
                    err_code_d = 2'd0;
                    state_d    = S_CFG;
                end
            end
            S_CFG: begin
                if (range_bad_c) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                    state_d    = S_IDLE;
                end else if (nsf_bad_c) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = S_IDLE;
                end else if (occi_bad_c) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                    state_d    = S_IDLE;
                end else begin
                    hop_d   = 1'b0;
                    k_d     = 3'd0;
                    m_d     = 3'd0;
                    nsf_d   = nsf0_c;
                    state_d = S_SP_START;
                end
            end
            S_SP_START: begin
                o_sp_start = 1'b1;
                state_d    = S_SP_WAIT;
            end
            S_SP_WAIT: begin
                if (i_sp_valid) begin
                    phi_d   = i_sp_phi;
                    last_d  = i_sp_done;
                    // data symbols sit on odd offsets: start + 2k + 1
                    sym_d   = ssym_q + {k_q, 1'b1};
                    ohop_d  = hop_q;
                    om_d    = m_q;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    if (!last_q) begin
                        k_d       = k_q + 3'd1;
                        m_d       = m_q + 3'd1;
                        o_sp_next = 1'b1;
                        state_d   = S_SP_WAIT;
                    end else if (hop_en_q && !hop_q) begin
                        hop_d   = 1'b1;
                        k_d     = k_q + 3'd1;
                        m_d     = 3'd0;
                        nsf_d   = nsf1_c;
                        state_d = S_SP_START;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            nsym_q     <= '0;
            ssym_q     <= '0;
            hop_en_q   <= 1'b0;
            occi_q     <= '0;
            nsf_q      <= '0;
            hop_q      <= 1'b0;
            k_q        <= '0;
            m_q        <= '0;
            last_q     <= 1'b0;
            phi_q      <= '0;
            sym_q      <= '0;
            ohop_q     <= 1'b0;
            om_q       <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            nsym_q     <= nsym_d;
            ssym_q     <= ssym_d;
            hop_en_q   <= hop_en_d;
            occi_q     <= occi_d;
            nsf_q      <= nsf_d;
            hop_q      <= hop_d;
            k_q        <= k_d;
            m_q        <= m_d;
            last_q     <= last_d;
            phi_q      <= phi_d;
            sym_q      <= sym_d;
            ohop_q     <= ohop_d;
            om_q       <= om_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign o_sp_nsf   = nsf_q;
    assign o_sp_occi  = occi_q;
    assign o_phi      = phi_q;
    assign o_sym      = sym_q;
    assign o_hop      = ohop_q;
    assign o_m        = om_q;
    assign o_busy     = (state_q != S_IDLE);
    assign o_err      = err_q;
    assign o_err_code = err_code_q;

endmodule

// File: tb/tb_cyc_24_pucch1_sched.sv
// -----------------------------------------------------------------------------
// Testbench for cyc_24_pucch1_sched.
//
// A behavioural spreader answers each start/next strobe one cycle later with
// the 38.211 orthogonal cover phase. Stimulus pushes the expected beats and
// nSF values into queues. A monitor pops these queues and compares them on
// every accepted beat and every spreader start.
// -----------------------------------------------------------------------------
module tb_cyc_24_pucch1_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic [3:0] i_nsym;
    logic [3:0] i_start_sym;
    logic       i_hop;
    logic [2:0] i_occi;
    logic       o_sp_start;
    logic       o_sp_next;
    logic [2:0] o_sp_nsf;
    logic [2:0] o_sp_occi;
    logic [4:0] i_sp_phi;
    logic       i_sp_valid;
    logic       i_sp_done;
    logic       o_valid;
    logic       i_ready;
    logic [4:0] o_phi;
    logic [3:0] o_sym;
    logic       o_hop;
    logic [2:0] o_m;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic [1:0] o_err_code;

    always #5 clk = ~clk;

    cyc_24_pucch1_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_nsym     (i_nsym),
        .i_start_sym(i_start_sym),
        .i_hop      (i_hop),
        .i_occi     (i_occi),
        .o_sp_start (o_sp_start),
        .o_sp_next  (o_sp_next),
        .o_sp_nsf   (o_sp_nsf),
        .o_sp_occi  (o_sp_occi),
        .i_sp_phi   (i_sp_phi),
        .i_sp_valid (i_sp_valid),
        .i_sp_done  (i_sp_done),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_phi      (o_phi),
        .o_sym      (o_sym),
        .o_hop      (o_hop),
        .o_m        (o_m),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_err_code (o_err_code)
    );

    typedef struct {
        int phi;
        int sym;
        int hop;
        int m;
    } beat_t;

    beat_t exp_q[$];
    int    nsf_q[$];
    int    tests      = 0;
    int    fails      = 0;
    int    beat_cnt   = 0;
    int    stall_beat = -1;
    int    stall_left = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // 38.211 time-domain OCC phases, converted to units of 2*pi/24
    function automatic int occ_phi(input int nsf, input int i, input int m);
        int r;
        r = 0;
        case (nsf)
            2: r = ((i * m) % 2) * 12;
            3: r = ((i * m) % 3) * 8;
            4: begin
                case (i)
                    1: r = ((m % 2) != 0) ? 12 : 0;
                    2: r = (m >= 2) ? 12 : 0;
                    3: r = (m == 1 || m == 2) ? 12 : 0;
                    default: r = 0;
                endcase
            end
            6: r = ((i * m) % 6) * 4;
            default: r = 0;
        endcase
        return r;
    endfunction

    // Spreader model: responds one cycle after a start/next strobe
    initial begin : spreader
        int   sp_m;
        int   nsf_s;
        int   occ_s;
        logic s;
        logic n;
        sp_m       = 0;
        i_sp_valid = 1'b0;
        i_sp_phi   = '0;
        i_sp_done  = 1'b0;
        forever begin
            @(negedge clk);
            s     = o_sp_start;
            n     = o_sp_next;
            nsf_s = int'(o_sp_nsf);
            occ_s = int'(o_sp_occi);
            @(posedge clk);
            #1;
            if (s) sp_m = 0;
            else if (n) sp_m = sp_m + 1;
            if (s || n) begin
                i_sp_valid = 1'b1;
                i_sp_phi   = 5'(occ_phi(nsf_s, occ_s, sp_m));
                i_sp_done  = (sp_m == nsf_s - 1);
            end else begin
                i_sp_valid = 1'b0;
                i_sp_done  = 1'b0;
            end
        end
    end

    // Downstream ready, with optional backpressure on one beat
    initial begin : ready_drv
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && beat_cnt == stall_beat && o_valid) begin
                i_ready    = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                i_ready = 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    initial begin : monitor
        bit    stalled;
        int    h_phi, h_sym, h_hop, h_m;
        beat_t e;
        stalled = 0;
        h_phi = 0; h_sym = 0; h_hop = 0; h_m = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    check("stall_valid", o_valid, 1);
                    check("stall_phi", o_phi, h_phi);
                    check("stall_sym", o_sym, h_sym);
                    check("stall_hop", o_hop, h_hop);
                    check("stall_m", o_m, h_m);
                end
                if (o_sp_start) begin
                    if (nsf_q.size() == 0) check("unexpected_sp_start", 1, 0);
                    else check("sp_nsf", o_sp_nsf, nsf_q.pop_front());
                end
                if (o_sp_next) begin
                    check("next_with_start", o_sp_start, 0);
                    check("next_outside_out", o_valid, 1);
                end
                if (o_valid && !i_ready) begin
                    check("no_next_in_stall", o_sp_next, 0);
                    stalled = 1;
                    h_phi = o_phi; h_sym = o_sym; h_hop = o_hop; h_m = o_m;
                end else begin
                    stalled = 0;
                end
                if (o_valid && i_ready) begin
                    beat_cnt++;
                    $display("[TB] beat phi=%0d sym=%0d hop=%0d m=%0d", o_phi, o_sym, o_hop, o_m);
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_phi", o_phi, e.phi);
                        check("beat_sym", o_sym, e.sym);
                        check("beat_hop", o_hop, e.hop);
                        check("beat_m", o_m, e.m);
                    end
                end
            end
        end
    end

    task automatic push_beat(input int phi, input int sym, input int hop, input int m);
        beat_t b;
        b.phi = phi; b.sym = sym; b.hop = hop; b.m = m;
        exp_q.push_back(b);
    endtask

    task automatic push_case_a(); // no hop, N=8, start 2, occi 3
        nsf_q.push_back(4);
        push_beat(0, 3, 0, 0);
        push_beat(12, 5, 0, 1);
        push_beat(12, 7, 0, 2);
        push_beat(0, 9, 0, 3);
    endtask

    task automatic push_case_b(); // hop, N=14, start 0, occi 1
        nsf_q.push_back(3);
        nsf_q.push_back(4);
        push_beat(0, 1, 0, 0);
        push_beat(8, 3, 0, 1);
        push_beat(16, 5, 0, 2);
        push_beat(0, 7, 1, 0);
        push_beat(12, 9, 1, 1);
        push_beat(0, 11, 1, 2);
        push_beat(12, 13, 1, 3);
    endtask

    // Drives i_start for cycle 0; returns 1 time unit into cycle 1
    task automatic start_pulse(input int n, input int ss, input int hop, input int occi);
        @(posedge clk);
        #1;
        i_nsym      = 4'(n);
        i_start_sym = 4'(ss);
        i_hop       = hop[0];
        i_occi      = 3'(occi);
        i_start     = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic launch(input int n, input int ss, input int hop, input int occi, input bit timing);
        beat_cnt = 0;
        start_pulse(n, ss, hop, occi);
        @(negedge clk); // cycle 1
        check("cfg_busy", o_busy, 1);
        check("err_code_cleared", o_err_code, 0);
        if (timing) begin
            @(negedge clk); // cycle 2
            check("sp_start_cycle2", o_sp_start, 1);
            @(negedge clk); // cycle 3
            check("no_valid_cycle3", o_valid, 0);
            @(negedge clk); // cycle 4
            check("first_valid_cycle4", o_valid, 1);
        end
    endtask

    task automatic finish_wait();
        bit got;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (o_done) got = 1;
        end
        check("done_seen", got, 1);
        check("beats_left", exp_q.size(), 0);
        check("nsf_left", nsf_q.size(), 0);
        @(negedge clk);
        check("idle_after_done", o_busy, 0);
    endtask

    task automatic reject(input int n, input int ss, input int hop, input int occi, input int code);
        start_pulse(n, ss, hop, occi);
        @(negedge clk); // cycle 1
        check("rej_no_err_c1", o_err, 0);
        @(negedge clk); // cycle 2
        check("rej_err_pulse", o_err, 1);
        check("rej_code", o_err_code, code);
        check("rej_idle", o_busy, 0);
        @(negedge clk); // cycle 3
        check("rej_err_single", o_err, 0);
        check("rej_code_held", o_err_code, code);
    endtask

    initial begin : stim
        bit got;
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_nsym      = '0;
        i_start_sym = '0;
        i_hop       = 1'b0;
        i_occi      = '0;

        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", int'({o_valid, o_busy, o_sp_start, o_sp_next, o_sp_nsf, o_sp_occi,
                                     o_phi, o_sym, o_hop, o_m, o_done, o_err, o_err_code}), 0);
        rst_n = 1'b1;

        // Basic no-hop run, with first-beat latency checked
        push_case_a();
        launch(8, 2, 0, 3, 1'b1);
        finish_wait();

        // Hopping run
        push_case_b();
        launch(14, 0, 1, 1, 1'b0);
        finish_wait();

        // Rejects
        reject(14, 0, 0, 0, 2);
        reject(4, 0, 0, 2, 3);
        reject(6, 10, 0, 0, 1);

        // Backpressure on the second beat
        stall_beat = 1;
        stall_left = 5;
        push_case_a();
        launch(8, 2, 0, 3, 1'b0);
        finish_wait();
        check("stall_consumed", stall_left, 0);
        stall_beat = -1;

        // i_start while busy is ignored
        push_case_a();
        launch(8, 2, 0, 3, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        i_nsym      = 4'd14;
        i_start_sym = 4'd0;
        i_hop       = 1'b1;
        i_occi      = 3'd0;
        i_start     = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(negedge clk);
        check("busy_start_occi", o_sp_occi, 3);
        check("busy_start_busy", o_busy, 1);
        finish_wait();

        // Reset in the middle of the second hop
        push_case_b();
        launch(14, 0, 1, 1, 1'b0);
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (beat_cnt >= 4) got = 1;
        end
        check("reached_hop1", got, 1);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", int'({o_valid, o_busy, o_sp_start, o_sp_next, o_sp_nsf, o_sp_occi,
                                            o_phi, o_sym, o_hop, o_m, o_done, o_err, o_err_code}), 0);
        exp_q.delete();
        nsf_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh run after reset
        push_case_b();
        launch(14, 0, 1, 1, 1'b0);
        finish_wait();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
